// File: rtl/mult_booth_pkg.sv
// Shared types and helpers for the iterative radix-4 Booth multiplier datapath.
package mult_booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int calc_pw(input int w);
    return 2 * w;
  endfunction

  function automatic int calc_nd(input int w);
    return w / 2;
  endfunction

  // Radix-4 Booth recoding of one overlapping triplet {b[2k+1], b[2k], b[2k-1]}.
  function automatic booth_digit_t booth_encode(input logic [2:0] t);
    booth_digit_t d;
    d = '0;
    case (t)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_csa_accum_csa_row.sv
// PW-bit 3:2 compressor row; carry row is pre-shifted with the top carry dropped.
module csa_row #(
  parameter int PW = 8
) (
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  input  logic [PW-1:0] z,
  output logic [PW-1:0] s,
  output logic [PW-1:0] c
);

  logic [PW-1:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x & y) | (x & z) | (y & z);
  assign c   = {maj[PW-2:0], 1'b0};

endmodule

// File: rtl/booth4_csa_accum.sv
// Iterative radix-4 Booth multiplier front end: one Booth digit per cycle into a
// carry-save pair that feeds the downstream carry-propagate adder directly.
module booth4_csa_accum
  import mult_booth_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   sum_row,
  output logic [2*W-1:0]   carry_row
);

  localparam int PW = calc_pw(W);
  localparam int ND = calc_nd(W);
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  state_e        state_q;
  logic [PW-1:0] a_q;
  logic [W:0]    bx_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] sum_q;
  logic [PW-1:0] carry_q;
  logic          out_valid_q;

  logic [2:0]    triplet;
  booth_digit_t  digit;
  logic [PW-1:0] mag;
  logic [PW-1:0] pp;
  logic [PW-1:0] sum_d;
  logic [PW-1:0] carry_d;

  // Partial product for the current digit, weighted by 4^k.
  always_comb begin
    triplet = 3'(bx_q >> {cnt_q, 1'b0});
    digit   = booth_encode(triplet);
    mag     = '0;
    if (digit.two)      mag = a_q << 1;
    else if (digit.one) mag = a_q;
    pp = digit.neg ? (~mag + PW'(1)) : mag;
    pp = pp << {cnt_q, 1'b0};
  end

  csa_row #(.PW(PW)) u_csa (
    .x (sum_q),
    .y (carry_q),
    .z (pp),
    .s (sum_d),
    .c (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      bx_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= {{W{a_in[W-1]}}, a_in};
            bx_q    <= {b_in, 1'b0};
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(ND - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum_row   = sum_q;
  assign carry_row = carry_q;

endmodule

// File: tb/tb_booth4_csa_accum.sv
// Directed and exhaustive checks of the 4-bit Booth carry-save multiplier front end.
module tb_booth4_csa_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_row;
  logic [7:0] carry_row;

  int nvec = 0;
  int nerr = 0;

  booth4_csa_accum #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_row   (sum_row),
    .carry_row (carry_row)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Downstream 8-bit CPA: cout dropped.
  function automatic logic [7:0] cpa(input logic [7:0] x, input logic [7:0] y);
    return x + y;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_prod);
    a_in = a; b_in = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_rdy_accum"}, 16'(in_ready), 16'd0);
    check({tag, "_ov_accum"}, 16'(out_valid), 16'd0);
    tick();
    check({tag, "_ov_k1"}, 16'(out_valid), 16'd0);
    tick();
    check({tag, "_ov_done"}, 16'(out_valid), 16'd1);
    check({tag, "_rdy_done"}, 16'(in_ready), 16'd0);
    check({tag, "_prod"}, 16'(cpa(sum_row, carry_row)), 16'(exp_prod));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rdy_idle"}, 16'(in_ready), 16'd1);
    check({tag, "_ov_idle"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    logic [7:0] snap_s, snap_c;
    int sa, sb, exp_p, cyc;
    bit got;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_sum", 16'(sum_row), 16'd0);
    check("rst_carry", 16'(carry_row), 16'd0);

    run_op("p3x5", 4'd3, 4'd5, 8'h0F);
    run_op("m8xm8", 4'h8, 4'h8, 8'h40);
    run_op("m8x7", 4'h8, 4'd7, 8'hC8);
    run_op("p7xm1", 4'd7, 4'hF, 8'hF9);

    // Back-pressure: result held, new operands ignored.
    a_in = 4'd5; b_in = 4'hD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bp_ov0", 16'(out_valid), 16'd1);
    snap_s = sum_row; snap_c = carry_row;
    a_in = 4'd1; b_in = 4'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ov", 16'(out_valid), 16'd1);
      check("bp_rdy", 16'(in_ready), 16'd0);
      check("bp_prod", 16'(cpa(sum_row, carry_row)), 16'h00F1);
      check("bp_sum_stable", 16'(sum_row), 16'(snap_s));
      check("bp_carry_stable", 16'(carry_row), 16'(snap_c));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rdy_idle", 16'(in_ready), 16'd1);
    check("bp_ov_idle", 16'(out_valid), 16'd0);

    // Reset on the first ACCUM cycle aborts the operation.
    a_in = 4'd3; b_in = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rdy", 16'(in_ready), 16'd1);
    check("abort_ov", 16'(out_valid), 16'd0);
    check("abort_sum", 16'(sum_row), 16'd0);
    check("abort_carry", 16'(carry_row), 16'd0);
    tick();
    tick();
    check("abort_no_result", 16'(out_valid), 16'd0);
    run_op("p2x2", 4'd2, 4'd2, 8'h04);

    // All 256 signed pairs with random output stalls.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        exp_p = (sa * sb) & 255;
        cyc = 0;
        while (!in_ready && cyc < 20) begin tick(); cyc++; end
        check("ex_rdy", 16'(in_ready), 16'd1);
        a_in = 4'(a); b_in = 4'(b); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 40) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            check("ex_prod", 16'(cpa(sum_row, carry_row)), 16'(exp_p));
            got = 1'b1;
          end
          tick();
          cyc++;
        end
        out_ready = 1'b0;
        check("ex_result_seen", 16'(got), 16'd1);
        check("ex_no_dup", 16'(out_valid), 16'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
